mem_access_ctrl: RTL
====================

# mem_access_ctrl

Parametrised memory-stage control sequencer for the LC-3b pipeline. It takes over the data-memory side of the datapath for every load/store opcode, including the multi-access LDI/STI and the TRAP vector fetch. It drives the data-cache handshake, formats byte accesses, and holds the pipeline with `stall` until the instruction in MEM has finished. It sits between the EX/MEM pipeline register and the data cache, and replaces the fixed single-cycle `read_memory`/`write_memory` decode.

## Interface
- `ADDR_WIDTH`, 16: address width.
- `DATA_WIDTH`, 16: data width. Must be even; the byte lane is `DATA_WIDTH/2`.
- `INDIRECT_EN`, 1: 1 enables LDI/STI. 0 makes them illegal.
- `BYTE_EN`, 1: 1 enables LDB/STB. 0 makes them illegal.

Ports. Reset is asynchronous, active-low; one clock.
- `clk` in 1: clock.
- `reset_n` in 1: asynchronous active-low reset.
- `valid` in 1: MEM stage holds a real instruction.
- `opcode` in 4: `lc3b_opcode` of that instruction.
- `addr_in` in `ADDR_WIDTH`: effective address from EX.
- `store_data` in `DATA_WIDTH`: SR value for stores.
- `dmem_resp` in 1: cache completed the current access.
- `dmem_rdata` in `DATA_WIDTH`: cache read data.
- `dmem_read` out 1: cache read request.
- `dmem_write` out 1: cache write request.
- `dmem_addr` out `ADDR_WIDTH`: cache address.
- `dmem_wdata` out `DATA_WIDTH`: cache write data.
- `dmem_byte_enable` out 2: byte lanes, bit1 is the high byte.
- `stall` out 1: freeze the pipeline this cycle.
- `load_data` out `DATA_WIDTH`: registered, formatted load result.
- `done` out 1: one-cycle pulse when the access sequence completes.
- `illegal` out 1: one-cycle pulse for a disabled opcode.

## Operation
- Memory ops:
  - Reads: LDR, LDB, LDI, TRAP.
  - Writes: STR, STB.
  - Read then write: STI.
  - All other opcodes: `stall`=0, no request, no state change.
- FSM states: IDLE, ACC1, ACC2, DONE.
  - IDLE → ACC1 when `valid` and an enabled memory op.
  - ACC1 on `dmem_resp`: → ACC2 if LDI/STI, else → DONE.
  - ACC2 on `dmem_resp`: → DONE.
  - DONE → IDLE unconditionally.
- ACC1 access:
  - `dmem_addr` = `addr_in`. LDB/STB force bit0 to 0 on the bus.
  - `dmem_read`=1 for LDR/LDB/LDI/TRAP/STI. `dmem_write`=1 for STR/STB.
  - For LDI/STI, `dmem_rdata` is captured into the internal pointer register on `dmem_resp`.
- ACC2 access:
  - `dmem_addr` = pointer register.
  - LDI: read. STI: write `store_data`, `dmem_byte_enable`=11.
- Byte formatting:
  - STB: `dmem_wdata` = {`store_data`[7:0], `store_data`[7:0]}; `dmem_byte_enable` = 10 if `addr_in`[0] else 01.
  - All other requests use byte enable 11 and `dmem_wdata` = `store_data`.
  - LDB: `load_data` = SEXT of the selected byte (high byte if `addr_in`[0]).
  - LDR/LDI/TRAP: `load_data` = the final read word.
  - `load_data` updates only on the final `dmem_resp` of a read sequence. It holds otherwise; stores leave it unchanged.
- `stall` = `valid` & enabled memory op & state≠DONE. This is combinational, so it is high in the IDLE entry cycle.
- `done` = (state==DONE). In that cycle `stall`=0 and the pipeline advances.
- Illegal opcode (LDI/STI with `INDIRECT_EN`=0, LDB/STB with `BYTE_EN`=0) in IDLE with `valid`:
  - `illegal` is a combinational pulse that cycle.
  - No request, `stall`=0, stays in IDLE.
- `dmem_read` and `dmem_write` are never both 1. Both are 0 in IDLE and DONE.
- `dmem_resp` in IDLE or DONE is ignored.
- `opcode`, `addr_in` and `store_data` must stay stable while `stall`=1; the bench asserts this. If `valid` drops in ACC1/ACC2, the outstanding access still completes and the FSM returns through DONE.

## Timing
- Reset values (asynchronous): state=IDLE, pointer=0, `load_data`=0. All request outputs, `stall`, `done` and `illegal` are 0.
- Reset asserted mid-access: requests drop immediately and the FSM is in IDLE after deassert.
- Request outputs are held stable from entry into ACC1/ACC2 until the `dmem_resp` cycle.
- Latency with a cache that responds in its first request cycle:
  - Single access: `stall` high for cycles 0–1, `done` in cycle 2.
  - LDI/STI: `stall` high for cycles 0–2, `done` in cycle 3.
  - Each cache wait cycle adds one stall cycle.
- Back-to-back memory ops: the next op enters IDLE the cycle after DONE. There are always 3 or more cycles per op.

## Test plan
- LDR, `addr_in`=0x1000, resp in 1 cycle with rdata 0xBEEF → `dmem_read` for one cycle at 0x1000; `load_data`=0xBEEF; `done` in cycle 2; `stall`=1 for cycles 0–1.
- LDB, `addr_in`=0x2001, rdata 0x80AA → `dmem_addr`=0x2000, `load_data`=0xFF80. Repeat with 0x2000 → 0xFFAA.
- STB, `addr_in`=0x3001, `store_data`=0x1234 → `dmem_wdata`=0x3434, `dmem_byte_enable`=10, `load_data` unchanged.
- LDI, `addr_in`=0x4000, first rdata 0x5000 after 3 wait cycles, second rdata 0x00C3 → reads at 0x4000 then 0x5000; `load_data`=0x00C3; `stall`=1 for cycles 0–5.
- STI with `INDIRECT_EN`=0 → `illegal` pulse, no request, `stall`=0. With `INDIRECT_EN`=1 → read at `addr_in`, then write of `store_data` at the pointer with byte enable 11.
- `reset_n` low during ACC2 of an LDI → requests 0 immediately, `load_data`=0; the next LDR after reset completes normally.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// LC-3b memory-stage sequencer: drives the data-cache handshake for loads, stores,
// LDI/STI indirection and TRAP vector fetch, and stalls the pipeline until done.
module mem_access_ctrl #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter bit INDIRECT_EN = 1'b1,
  parameter bit BYTE_EN     = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  valid,
  input  logic [3:0]            opcode,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic                  dmem_resp,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  dmem_read,
  output logic                  dmem_write,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic [1:0]            dmem_byte_enable,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  done,
  output logic                  illegal
);

  localparam int HALF = DATA_WIDTH / 2;

  typedef enum logic [3:0] {
    OP_BR  = 4'h0, OP_ADD = 4'h1, OP_LDB = 4'h2, OP_STB  = 4'h3,
    OP_JSR = 4'h4, OP_AND = 4'h5, OP_LDR = 4'h6, OP_STR  = 4'h7,
    OP_RTI = 4'h8, OP_NOT = 4'h9, OP_LDI = 4'hA, OP_STI  = 4'hB,
    OP_JMP = 4'hC, OP_SHF = 4'hD, OP_LEA = 4'hE, OP_TRAP = 4'hF
  } lc3b_opcode_e;

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0]   load_data_q, load_data_d;
  lc3b_opcode_e            op;
  logic                    is_byte, is_ind, is_rd, is_wr, op_mem, op_legal;
  logic [HALF-1:0]         rbyte;

  assign op = lc3b_opcode_e'(opcode);

  // is_rd marks sequences whose final access is a read (LDI included).
  always_comb begin
    is_byte  = (op == OP_LDB) || (op == OP_STB);
    is_ind   = (op == OP_LDI) || (op == OP_STI);
    is_rd    = op inside {OP_LDR, OP_LDB, OP_LDI, OP_TRAP};
    is_wr    = op inside {OP_STR, OP_STB};
    op_mem   = is_rd || is_wr || (op == OP_STI);
    op_legal = op_mem && !(is_ind && !INDIRECT_EN) && !(is_byte && !BYTE_EN);
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no branch infers a latch.
    state_d          = state_q;
    ptr_d            = ptr_q;
    load_data_d      = load_data_q;
    dmem_read        = 1'b0;
    dmem_write       = 1'b0;
    dmem_addr        = '0;
    dmem_wdata       = '0;
    dmem_byte_enable = 2'b00;
    done             = 1'b0;
    illegal          = 1'b0;
    stall            = valid && op_legal && (state_q != DONE);
    rbyte            = addr_in[0] ? dmem_rdata[DATA_WIDTH-1:HALF] : dmem_rdata[HALF-1:0];

    case (state_q)
      IDLE: begin
        if (valid) begin
          if (op_legal)    state_d = ACC1;
          else if (op_mem) illegal = 1'b1;
        end
      end

      ACC1: begin
        dmem_read        = is_rd || (op == OP_STI);
        dmem_write       = is_wr;
        dmem_addr        = addr_in;
        dmem_wdata       = store_data;
        dmem_byte_enable = 2'b11;
        if (is_byte) dmem_addr[0] = 1'b0;
        if (op == OP_STB) begin
          dmem_wdata       = {2{store_data[HALF-1:0]}};
          dmem_byte_enable = addr_in[0] ? 2'b10 : 2'b01;
        end
        if (dmem_resp) begin
          if (is_ind) begin
            ptr_d   = ADDR_WIDTH'(dmem_rdata);
            state_d = ACC2;
          end else begin
            state_d = DONE;
            if (op == OP_LDB)  load_data_d = {{HALF{rbyte[HALF-1]}}, rbyte};
            else if (is_rd)    load_data_d = dmem_rdata;
          end
        end
      end

      ACC2: begin
        dmem_read        = (op == OP_LDI);
        dmem_write       = (op == OP_STI);
        dmem_addr        = ptr_q;
        dmem_wdata       = store_data;
        dmem_byte_enable = 2'b11;
        if (dmem_resp) begin
          state_d = DONE;
          if (op == OP_LDI) load_data_d = dmem_rdata;
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      load_data_q <= load_data_d;
    end
  end

  assign load_data = load_data_q;

endmodule
